// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: FCR bit positions, the
// receive-trigger encoding with its occupancy thresholds, and the state
// encoding of the RBR prefetch machine.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // FCR bit positions
  localparam int FCR_EN_BIT    = 0;
  localparam int FCR_FLUSH_BIT = 1;
  localparam int FCR_TRIG_LO   = 6;
  localparam int FCR_TRIG_HI   = 7;

  // Receive trigger select, FCR[7:6]
  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_e;

  localparam logic [4:0] THR_1  = 5'd1;
  localparam logic [4:0] THR_4  = 5'd4;
  localparam logic [4:0] THR_8  = 5'd8;
  localparam logic [4:0] THR_14 = 5'd14;

  // RBR prefetch state: holding register empty, read in flight, holding valid
  typedef enum logic [1:0] {
    PF_EMPTY = 2'd0,
    PF_WAIT  = 2'd1,
    PF_FULL  = 2'd2
  } pf_state_e;

  function automatic logic [4:0] trig_threshold(input trig_e trig);
    case (trig)
      TRIG_1:  return THR_1;
      TRIG_4:  return THR_4;
      TRIG_8:  return THR_8;
      TRIG_14: return THR_14;
      default: return THR_1;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// -----------------------------------------------------------------------------
// uart_rx_timeout
// Saturating character-timeout counter. Counts char_tick pulses while the
// receive path holds data and saturates at TO_CHARS; any receive/read/flush
// activity clears it.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   i_clr      clear counter (has priority over counting)
//   i_tick     one character time elapsed
//   i_active   data is pending (level > 0); counting is qualified by it
//   o_expired  counter has reached TO_CHARS
// -----------------------------------------------------------------------------
module uart_rx_timeout #(
  parameter int TO_CHARS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  input  logic i_active,
  output logic o_expired
);

  localparam int W = (TO_CHARS < 2) ? 1 : $clog2(TO_CHARS + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick && i_active && (r_cnt != W'(TO_CHARS))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = (r_cnt == W'(TO_CHARS));

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// Receive-side controller for the 16-entry UART FIFO. Writes received bytes
// into the FIFO, prefetches the FIFO head into the RBR holding register,
// applies FCR (enable / flush / trigger) and produces the received-data
// trigger, character-timeout and overrun indications. With the FIFO disabled
// it behaves as a 16450: a single holding register loaded straight from the
// receiver.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_valid, rx_data        byte from the bit-level receiver (1-cycle pulse)
//   char_tick                one pulse per character time
//   fcr_wr, fcr_data         FCR write: [0] fifo_en, [1] rx flush, [7:6] trigger
//   rbr_rd, lsr_rd           CPU reads of RBR / LSR (LSR read clears overrun)
//   fifo_winc, fifo_wdata    FIFO write port
//   fifo_rinc, fifo_rst      FIFO read enable, FIFO flush
//   fifo_rdata               FIFO head, valid the cycle after fifo_rinc
//   fifo_wfull, fifo_rempty  FIFO flags
//   fifo_cnt                 FIFO occupancy (registered, lags by one cycle)
//   rbr_data                 holding register
//   data_ready, overrun      LSR[0], LSR[1]
//   rx_int, to_int           trigger-level and character-timeout interrupts
// -----------------------------------------------------------------------------
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int TO_CHARS = 4,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             char_tick,
  input  logic             fcr_wr,
  input  logic [7:0]       fcr_data,
  input  logic             rbr_rd,
  input  logic             lsr_rd,
  output logic             fifo_winc,
  output logic [7:0]       fifo_wdata,
  output logic             fifo_rinc,
  output logic             fifo_rst,
  input  logic [7:0]       fifo_rdata,
  input  logic             fifo_wfull,
  input  logic             fifo_rempty,
  input  logic [CNT_W-1:0] fifo_cnt,
  output logic [7:0]       rbr_data,
  output logic             data_ready,
  output logic             overrun,
  output logic             rx_int,
  output logic             to_int
);

  logic             r_fcr_en;
  trig_e            r_trig;
  pf_state_e        r_state;
  pf_state_e        w_state_nxt;
  logic [7:0]       r_rbr_data;
  logic             r_overrun;

  logic             w_flush;
  logic             w_winc;
  logic             w_rinc;
  logic             w_load_fifo;
  logic             w_load_rx;
  logic             w_ovr_set;
  logic             w_data_ready;
  logic [CNT_W-1:0] w_level;
  logic             w_level_nz;
  logic             w_to_clr;
  logic             w_to_expired;
  logic             w_fcr_unused;

  // FCR[5:2] have no receive-side meaning.
  assign w_fcr_unused = ^fcr_data[5:2];

  // Flush on an explicit request or whenever the mode changes, so the FIFO
  // never carries bytes across a 16450/16550 switch. Reset masks it.
  assign w_flush = !rst && fcr_wr &&
                   (fcr_data[FCR_FLUSH_BIT] || (fcr_data[FCR_EN_BIT] != r_fcr_en));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcr_en <= 1'b0;
      r_trig   <= TRIG_1;
    end else if (fcr_wr) begin
      r_fcr_en <= fcr_data[FCR_EN_BIT];
      r_trig   <= trig_e'(fcr_data[FCR_TRIG_HI:FCR_TRIG_LO]);
    end
  end

  assign w_data_ready = (r_state == PF_FULL);

  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_winc      = 1'b0;
    w_rinc      = 1'b0;
    w_load_fifo = 1'b0;
    w_load_rx   = 1'b0;
    w_ovr_set   = 1'b0;

    if (w_flush) begin
      // A byte arriving with the flush is dropped silently.
      w_state_nxt = PF_EMPTY;
    end else if (r_fcr_en) begin
      w_winc    = rx_valid && !fifo_wfull;
      w_ovr_set = rx_valid && fifo_wfull;
      // Fetch the head when the holding register is empty, or when the CPU is
      // draining it this cycle (back-to-back reads).
      w_rinc    = !fifo_rempty &&
                  ((r_state == PF_EMPTY) || ((r_state == PF_FULL) && rbr_rd));
      case (r_state)
        PF_EMPTY: if (w_rinc) w_state_nxt = PF_WAIT;
        PF_WAIT: begin
          w_load_fifo = 1'b1;
          w_state_nxt = PF_FULL;
        end
        PF_FULL:  if (rbr_rd) w_state_nxt = w_rinc ? PF_WAIT : PF_EMPTY;
        default:  w_state_nxt = PF_EMPTY;
      endcase
    end else begin
      // 16450 mode: the holding register is the only storage; a new byte
      // overwrites an unread one and flags overrun.
      if (rx_valid) begin
        w_load_rx   = 1'b1;
        w_ovr_set   = w_data_ready;
        w_state_nxt = PF_FULL;
      end else if (rbr_rd && (r_state == PF_FULL)) begin
        w_state_nxt = PF_EMPTY;
      end
    end

    if (rst) begin
      w_winc = 1'b0;
      w_rinc = 1'b0;
    end
  end

  // NOTE: only control state and the holding register carry a reset; the FIFO
  // storage itself lives outside and is emptied through fifo_rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PF_EMPTY;
      r_rbr_data <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_fifo) begin
        r_rbr_data <= fifo_rdata;
      end else if (w_load_rx) begin
        r_rbr_data <= rx_data;
      end
    end
  end

  // A new overrun wins over a simultaneous LSR read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (lsr_rd) begin
      r_overrun <= 1'b0;
    end
  end

  // Bytes held = FIFO occupancy plus one for an occupied/pending holding reg.
  assign w_level    = fifo_cnt + CNT_W'(r_state != PF_EMPTY);
  assign w_level_nz = (w_level != '0);
  assign w_to_clr   = rx_valid || rbr_rd || w_flush;

  uart_rx_timeout #(
    .TO_CHARS (TO_CHARS)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_to_clr),
    .i_tick    (char_tick),
    .i_active  (w_level_nz),
    .o_expired (w_to_expired)
  );

  assign fifo_winc  = w_winc;
  assign fifo_wdata = rx_data;
  assign fifo_rinc  = w_rinc;
  assign fifo_rst   = w_flush;
  assign rbr_data   = r_rbr_data;
  assign data_ready = w_data_ready;
  assign overrun    = r_overrun;
  assign rx_int     = r_fcr_en ? (w_level >= CNT_W'(trig_threshold(r_trig)))
                               : w_data_ready;
  assign to_int     = r_fcr_en && w_level_nz && w_to_expired;

endmodule

// File: doc/uart_rx_fifo_ctrl.md
# uart_rx_fifo_ctrl

Receive-side controller for the 16-entry UART FIFO. It sits between the bit-level receiver and the CPU register interface. It writes received bytes into the FIFO and prefetches the FIFO head into the RBR holding register. It also applies the FCR configuration (enable, flush, trigger level) and raises the 16550-style received-data trigger, character-timeout and overrun indications.

## Interface
Parameters:
- TO_CHARS, 4: character times of inactivity before timeout interrupt
- CNT_W, 5: width of FIFO occupancy count (depth 16)

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle pulse: receiver has a byte
- rx_data  in  8  received byte
- char_tick  in  1  one-cycle pulse per character time, from baud generator
- fcr_wr  in  1  FCR write strobe
- fcr_data  in  8  FCR value: [0] fifo_en, [1] rx flush, [7:6] trigger select
- rbr_rd  in  1  CPU read of RBR
- lsr_rd  in  1  CPU read of LSR, clears overrun
- fifo_winc  out  1  FIFO write enable
- fifo_wdata  out  8  FIFO write data
- fifo_rinc  out  1  FIFO read enable
- fifo_rst  out  1  FIFO flush, high active
- fifo_rdata  in  8  FIFO registered output, updated the cycle after fifo_rinc
- fifo_wfull  in  1  FIFO full
- fifo_rempty  in  1  FIFO empty
- fifo_cnt  in  5  FIFO occupancy, registered, lags pointers by 1 cycle
- rbr_data  out  8  holding register
- data_ready  out  1  LSR[0]
- overrun  out  1  LSR[1]
- rx_int  out  1  trigger-level interrupt
- to_int  out  1  character-timeout interrupt

## Operation
- Reset (rst=1 at a clock edge): fcr_en=0, trig=00, state EMPTY, rbr_data=0, and data_ready, overrun, rx_int, to_int, fifo_rst all 0. Timeout counter = 0.
- FCR write: latch fifo_en and trig. fifo_rst pulses for exactly one cycle if fcr_data[1]=1 or fifo_en changes. A flush also sets state EMPTY, clears data_ready, to_int and the timeout counter, and leaves overrun unchanged.
- A rx_valid in the same cycle as a flush is discarded without setting overrun.
- fifo_en=1 write path: fifo_winc = rx_valid & !fifo_wfull & !flushing (combinational), with fifo_wdata = rx_data. rx_valid while fifo_wfull drops the byte and sets overrun.
- fifo_en=0 (16450 mode): fifo_winc and fifo_rinc stay 0. rx_valid loads rbr_data and sets data_ready. If data_ready is already 1, the new byte still overwrites rbr_data and overrun is set.
- Prefetch FSM (fifo_en=1), fifo_rinc = (EMPTY | (FULL & rbr_rd)) & !fifo_rempty:
  - EMPTY: if fifo_rinc then WAIT.
  - WAIT: capture fifo_rdata into rbr_data, then FULL.
  - FULL: on rbr_rd, go to WAIT if fifo_rinc, else EMPTY.
  - data_ready = (state==FULL).
- rbr_rd in EMPTY or WAIT has no effect.
- overrun stays 1 until lsr_rd. If lsr_rd and a new overrun occur in the same cycle, overrun ends at 1.
- Level = fifo_cnt + (state!=EMPTY). Trigger thresholds: 00→1, 01→4, 10→8, 11→14.
- rx_int = fifo_en & level ≥ threshold. In 16450 mode, rx_int = data_ready.
- Timeout counter:
  - Cleared on rx_valid or rbr_rd.
  - Otherwise increments on char_tick while level>0, saturating at TO_CHARS.
  - to_int = fifo_en & level>0 & counter==TO_CHARS.
  - to_int drops the cycle after rbr_rd, rx_valid or a flush.

## Timing
- rx_valid in cycle N (FIFO empty, state EMPTY): fifo_winc in N, fifo_rinc in N+1, WAIT in N+2, data_ready=1 in N+3.
- Back-to-back reads: rbr_rd in M with a non-empty FIFO gives data_ready=0 in M+1 and data_ready=1 with the next byte in M+2.
- level and rx_int may lag the FIFO pointers by up to 2 cycles because of fifo_cnt registration. This lag is accepted.
- The rst=1 cycle overrides every other input.

## Structure
- Shared package uart_pkg holds:
  - FCR bit positions
  - trigger encoding and threshold constants (1, 4, 8, 14)
  - prefetch state enum {EMPTY, WAIT, FULL}
- One sub-module, uart_rx_timeout: saturating character-timeout counter with a clear input and a level>0 qualifier.

## Test plan
- After reset, FCR=0x01: write 3 bytes 0xA1, 0xA2, 0xA3. Expect data_ready 3 cycles after the first write and rbr_data=0xA1. Three rbr_rd return 0xA1, 0xA2, 0xA3, each with a 1-cycle data_ready gap, then data_ready=0.
- Trigger select 10 (threshold 8): 7 writes give rx_int=0. The 8th write gives rx_int=1 within 2 cycles. One rbr_rd drops rx_int.
- 17 writes with no reads (16 FIFO entries, the holding register having taken the first). 18th write: overrun=1. lsr_rd gives overrun=0. Readback returns only the first 17 bytes.
- One byte stored, 4 char_tick pulses with no other activity: to_int=1 after the 4th tick. rbr_rd clears it. A 3-tick window never asserts it.
- FCR=0x03 with rx_valid in the same cycle and 5 bytes queued: fifo_rst pulses one cycle, data_ready=0, the concurrent byte is lost, and overrun is unchanged.
- FCR=0x00 (16450 mode): two rx_valid pulses without a read leave rbr_data equal to the second byte with overrun=1. fifo_winc never asserts.
